// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//   Radix-2 shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   Operands are unsigned or two's complement (signed_mode). The magnitudes are
//   multiplied unsigned, and the sign is applied in the final FIX cycle.
//   The unit supports abort and reports completion with a one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        request a multiply (sampled only while idle)
//   signed_mode  1 = two's-complement operands, sampled with start
//   abort        synchronous cancel of an in-flight operation
//   a, b         multiplicand / multiplier, sampled with start
//   product      last completed result (registered, held between ops)
//   ready        high while idle
//   done         registered one-cycle pulse when product has just updated
// -----------------------------------------------------------------------------
module seq_mult_param #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 ready,
   output logic                 done
);

   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        count;
   logic                 neg;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       upper_sum;

   // The magnitude of the most negative value is 2^(WIDTH-1), and that value
   // still fits in WIDTH unsigned bits.
   always_comb begin
      a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (mplier[0] ? {1'b0, mcand} : '0);
   end

   assign ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         neg     <= 1'b0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  count  <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  // The carry out of the upper-half add becomes the new MSB
                  // after the right shift.
                  acc    <= {upper_sum, acc[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  count  <= count + CW'(1);
                  if (count == LAST)
                     state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!abort) begin
                  product <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                  done    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance (model-checked every cycle)
   logic        start = 1'b0, signed_mode = 1'b0, abort = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] product;
   logic        ready, done;

   // WIDTH=4 and WIDTH=16 instances (directed checks)
   logic        start4 = 1'b0, sm4 = 1'b0, abort4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  product4;
   logic        ready4, done4;

   logic        start16 = 1'b0, sm16 = 1'b0, abort16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] product16;
   logic        ready16, done16;

   seq_mult_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .abort(abort), .a(a), .b(b), .product(product), .ready(ready), .done(done));

   seq_mult_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .abort(abort4), .a(a4), .b(b4), .product(product4), .ready(ready4), .done(done4));

   seq_mult_param #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .abort(abort16), .a(a16), .b(b16), .product(product16), .ready(ready16), .done(done16));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference product from plain integer arithmetic.
   function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
      longint px, py;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      return 16'(px * py);
   endfunction

   // Behavioural model: an accepted op delivers its result WIDTH+1 edges later
   // unless aborted; m_left counts edges remaining until delivery.
   int          m_left = 0;
   logic [15:0] m_res  = '0;
   logic [15:0] m_prod = '0;
   logic        m_done = 1'b0;
   bit          check_en = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left = 0;
         m_prod = '0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left == 0) begin
            if (start) begin
               m_left = 9;
               m_res  = ref8(a, b, signed_mode);
            end
         end else if (abort) begin
            m_left = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_prod = m_res;
               m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc ready",   ready,   (m_left == 0));
         chk("cyc done",    done,    m_done);
         chk("cyc product", product, m_prod);
      end
   end

   // Called at posedge+1 with the unit idle; returns in the done cycle.
   task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [15:0] exp, input string nm);
      int n;
      bit seen;
      a = x; b = y; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      chk({nm, " latency"}, n, 9);
      chk({nm, " product"}, product, exp);
   endtask

   task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic s,
                       input logic [7:0] exp, input string nm);
      int n;
      bit seen;
      a4 = x; b4 = y; sm4 = s; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = '0; b4 = '0;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done4) seen = 1'b1;
      end
      chk({nm, " latency"}, n, 5);
      chk({nm, " product"}, product4, exp);
   endtask

   task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [31:0] exp, input string nm);
      int n;
      bit seen;
      a16 = x; b16 = y; sm16 = s; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = '0; b16 = '0;
      n = 0; seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (done16) seen = 1'b1;
      end
      chk({nm, " latency"}, n, 17);
      chk({nm, " product"}, product16, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone, first, second;

      // Pin the model against hand-computed values.
      chk("model 255*255",  ref8(8'hFF, 8'hFF, 1'b0), 16'hFE01);
      chk("model -3*5",     ref8(8'hFD, 8'h05, 1'b1), 16'hFFF1);
      chk("model -128*-128", ref8(8'h80, 8'h80, 1'b1), 16'h4000);
      chk("model 127*-1",   ref8(8'h7F, 8'hFF, 1'b1), 16'hFF81);

      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset product", product, 16'h0000);
      chk("reset ready",   ready,   1);
      chk("reset done",    done,    0);
      check_en = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-CALC after a 0x1234 result.
      run8(8'd20, 8'd233, 1'b0, 16'h1234, "pre-reset");
      a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async reset product", product, 16'h0000);
      chk("async reset ready",   ready,   1);
      chk("async reset done",    done,    0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // Unsigned and signed directed vectors.
      run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u 255*255");
      run8(8'h00, 8'd173, 1'b0, 16'h0000, "u 0*173");
      run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s -3*5");
      run8(8'h80, 8'h80, 1'b1, 16'h4000, "s -128*-128");
      run8(8'h80, 8'h01, 1'b1, 16'hFF80, "s -128*1");
      run8(8'h7F, 8'hFF, 1'b1, 16'hFF81, "s 127*-1");
      run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s -1*-1");

      // Extra start pulses at edges 3 and 8 are ignored.
      a = 8'd6; b = 8'd7; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; first = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first == 0) first = k;
         end
         start = (k == 2 || k == 7);
      end
      start = 1'b0;
      chk("ignored start done count", ndone, 1);
      chk("ignored start done edge",  first, 9);
      chk("ignored start product",    product, 16'h002A);

      // Start held high through the done cycle: back-to-back ops.
      a = 8'd3; b = 8'd5; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 8'd4; b = 8'd5;
      ndone = 0; first = 0; second = 0;
      for (int k = 1; k <= 22; k++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first == 0) first = k;
            else second = k;
         end
         if (k == 9) chk("b2b first product", product, 16'h000F);
         if (k == 10) start = 1'b0;
      end
      chk("b2b done count",   ndone,  2);
      chk("b2b first edge",   first,  9);
      chk("b2b second edge",  second, 19);
      chk("b2b second product", product, 16'h0014);

      // Abort at edge 4.
      run8(8'd4, 8'd4, 1'b0, 16'h0010, "pre-abort");
      a = 8'd9; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort ready", ready, 1);
      chk("abort done",  done,  0);
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort no done",  ndone,   0);
      chk("abort product",  product, 16'h0010);
      run8(8'd9, 8'd9, 1'b0, 16'h0051, "post-abort");

      // Abort during FIX (edge 9): no result, product held.
      a = 8'd11; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("fix abort done",    done,    0);
      chk("fix abort product", product, 16'h0051);

      // Other widths.
      run4(4'h8, 4'h8, 1'b1, 8'h40, "w4 -8*-8");
      run4(4'hF, 4'hF, 1'b0, 8'hE1, "w4 15*15");
      run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 ffff*ffff");
      run16(16'h8000, 16'h0003, 1'b1, 32'hFFFE8000, "w16 -32768*3");

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised radix-2 shift-add sequential multiplier with integrated datapath and control. It is the next generation of the team's sequential multiplier: it takes WIDTH-bit operands in unsigned or two's-complement mode, supports abort, and reports completion with a registered one-cycle done pulse alongside the ready level. It sits beside the ALU as a multi-cycle functional unit and is driven by a start/ready handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- abort  input  1  synchronous cancel of an in-flight operation.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- product  output  2*WIDTH  last completed result; registered.
- ready  output  1  high in IDLE (the unit accepts start).
- done  output  1  registered one-cycle pulse: product has just been updated.

## Operation
- States: IDLE, CALC, FIX. Reset state is IDLE.
- IDLE: ready=1. On an edge with start=1: latch |a| and |b| (the magnitudes if signed_mode=1, else the raw values), latch neg = signed_mode & (a[MSB] ^ b[MSB]), clear the 2*WIDTH accumulator, set count=0, and go to CALC.
- CALC: each cycle, if multiplier LSB=1, add the multiplicand to the accumulator upper half (carry kept). Shift accumulator/multiplier right by 1, then count+1. On the edge where count==WIDTH-1, go to FIX. Counter width is $clog2(WIDTH).
- FIX: product <= neg ? two's-complement negation of the accumulator : accumulator. done <= 1. Go to IDLE.
- Magnitude of the most negative value (2^(WIDTH-1)) fits unsigned in WIDTH bits. No overflow is possible in either mode.
- product changes only on the FIX→IDLE edge and holds between operations. The accumulator is separate from product.
- start while in CALC or FIX is ignored. It is neither queued nor an error.
- abort=1 in CALC or FIX: go to IDLE on that edge, leave product unchanged, and do not pulse done. abort is ignored in IDLE. If abort and start are both high in IDLE, start wins.
- Reset (async, any state): state=IDLE, product=0, done=0, ready=1, count=0, accumulator=0, neg=0.

## Timing
- Call the edge that samples start in IDLE edge 0.
- CALC occupies edges 1..WIDTH. FIX is resolved at edge WIDTH+1.
- After edge WIDTH+1: product valid, done=1 for exactly one cycle, ready=1.
- Latency from the start edge to the done edge is WIDTH+1 edges (9 for WIDTH=8). Throughput is one result per WIDTH+2 cycles with back-to-back starts.
- start=1 during the done cycle is accepted. A new op begins that edge, and done falls.
- ready is low from edge 0 until edge WIDTH+1.
- ready and done are derived from registered state or flops; there is no combinational path from inputs to outputs.
- Operand inputs may change freely after edge 0.

## Test plan
- Reset: drive rst=0 mid-CALC with product previously 0x1234 → immediately product=0, ready=1, done=0. After release, start works normally.
- Unsigned, WIDTH=8: a=255, b=255, signed_mode=0 → done exactly 9 edges after the start edge, product=0xFE01. Also a=0, b=173 → product=0x0000.
- Signed, WIDTH=8: a=-3 (0xFD), b=5 → 0xFFF1. a=-128, b=-128 → 0x4000. a=-128, b=1 → 0xFF80. a=127, b=-1 → 0xFF81.
- Handshake: start pulsed again at edges 3 and 8 of an op with a=6, b=7 → ignored, product=42 (0x002A). Start held high through the done cycle → second op accepted on the done edge, with one done per op.
- Abort: a=9, b=9 after a previous result of 0x0010, abort at edge 4 → ready=1 the next cycle, no done, product stays 0x0010. The next op computes correctly.
- Parametrisation: WIDTH=4, signed a=-8, b=-8 → product=0x40, done 5 edges after start. WIDTH=16, unsigned 0xFFFF*0xFFFF → 0xFFFE0001 after 17 edges.
